// File: rtl/axi_addr_window_monitor_if.sv
// AW/AR address-channel bundle for the window monitor: upstream (s_*) and downstream (m_*).
// Ports: slave = monitor view (accepts s_*, drives m_*); master = environment view.
interface axi_addr_window_monitor_if #(
    parameter int AXI_ADDR_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0] s_awaddr_i;
    logic                      s_awvalid_i;
    logic                      s_awready_o;
    logic [AXI_ADDR_WIDTH-1:0] m_awaddr_o;
    logic                      m_awvalid_o;
    logic                      m_awready_i;
    logic [AXI_ADDR_WIDTH-1:0] s_araddr_i;
    logic                      s_arvalid_i;
    logic                      s_arready_o;
    logic [AXI_ADDR_WIDTH-1:0] m_araddr_o;
    logic                      m_arvalid_o;
    logic                      m_arready_i;

    modport slave (
        input  s_awaddr_i, s_awvalid_i, m_awready_i,
        input  s_araddr_i, s_arvalid_i, m_arready_i,
        output s_awready_o, m_awaddr_o, m_awvalid_o,
        output s_arready_o, m_araddr_o, m_arvalid_o
    );

    modport master (
        output s_awaddr_i, s_awvalid_i, m_awready_i,
        output s_araddr_i, s_arvalid_i, m_arready_i,
        input  s_awready_o, m_awaddr_o, m_awvalid_o,
        input  s_arready_o, m_araddr_o, m_arvalid_o
    );
endinterface

// File: rtl/axi_addr_window_monitor.sv
// Registered AW/AR skid slices with address-window checking, sticky fault record and
// saturating violation counter. Ports: S_AXI_ACLK/S_AXI_ARESET, window bounds, clear_i,
// bus (AW/AR channels), fault_valid_o/fault_is_write_o/fault_addr_o, viol_count_o.
module addr_skid_slice #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_addr,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_addr,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         accept
);
    logic [W-1:0] skid_addr;
    logic         skid_valid;
    logic         drain;

    // skid only fills while the out reg is held, so ready is simply "skid empty"
    assign s_ready = ~skid_valid;
    assign accept  = s_valid & ~skid_valid;
    assign drain   = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_addr     <= '0;
            skid_valid <= 1'b0;
            skid_addr  <= '0;
        end else begin
            if (!m_valid || drain) begin
                if (skid_valid) begin
                    m_addr     <= skid_addr;
                    m_valid    <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    m_addr  <= s_addr;
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_addr  <= s_addr;
                skid_valid <= 1'b1;
            end
        end
    end
endmodule

module axi_addr_window_monitor #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      S_AXI_ARESET,
    input  logic [AXI_ADDR_WIDTH-1:0] win_base_i,
    input  logic [AXI_ADDR_WIDTH-1:0] win_limit_i,
    input  logic                      clear_i,
    axi_addr_window_monitor_if.slave  bus,
    output logic                      fault_valid_o,
    output logic                      fault_is_write_o,
    output logic [AXI_ADDR_WIDTH-1:0] fault_addr_o,
    output logic [CNT_WIDTH-1:0]      viol_count_o
);
    logic aw_acc, ar_acc;
    logic aw_viol, ar_viol;

    logic                      fv_d, fw_d;
    logic [AXI_ADDR_WIDTH-1:0] fa_d;
    logic [CNT_WIDTH-1:0]      cnt_base, cnt_d;
    logic [CNT_WIDTH:0]        cnt_sum;

    addr_skid_slice #(.W(AXI_ADDR_WIDTH)) u_aw (
        .clk     (S_AXI_ACLK),
        .rst     (S_AXI_ARESET),
        .s_addr  (bus.s_awaddr_i),
        .s_valid (bus.s_awvalid_i),
        .s_ready (bus.s_awready_o),
        .m_addr  (bus.m_awaddr_o),
        .m_valid (bus.m_awvalid_o),
        .m_ready (bus.m_awready_i),
        .accept  (aw_acc)
    );

    addr_skid_slice #(.W(AXI_ADDR_WIDTH)) u_ar (
        .clk     (S_AXI_ACLK),
        .rst     (S_AXI_ARESET),
        .s_addr  (bus.s_araddr_i),
        .s_valid (bus.s_arvalid_i),
        .s_ready (bus.s_arready_o),
        .m_addr  (bus.m_araddr_o),
        .m_valid (bus.m_arvalid_o),
        .m_ready (bus.m_arready_i),
        .accept  (ar_acc)
    );

    // limit <= base makes the two tests cover the whole space: everything violates
    assign aw_viol = aw_acc & ((bus.s_awaddr_i < win_base_i) |
                               (bus.s_awaddr_i >= win_limit_i));
    assign ar_viol = ar_acc & ((bus.s_araddr_i < win_base_i) |
                               (bus.s_araddr_i >= win_limit_i));

    // clear is applied first, then this cycle's violations land on the cleared state
    always_comb begin
        fv_d     = clear_i ? 1'b0 : fault_valid_o;
        fw_d     = clear_i ? 1'b0 : fault_is_write_o;
        fa_d     = clear_i ? '0 : fault_addr_o;
        cnt_base = clear_i ? '0 : viol_count_o;
        if (!fv_d && (aw_viol || ar_viol)) begin
            fv_d = 1'b1;
            fw_d = aw_viol;
            fa_d = aw_viol ? bus.s_awaddr_i : bus.s_araddr_i;
        end
        cnt_sum = {1'b0, cnt_base} + (CNT_WIDTH+1)'(aw_viol)
                                   + (CNT_WIDTH+1)'(ar_viol);
        cnt_d   = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            fault_valid_o    <= 1'b0;
            fault_is_write_o <= 1'b0;
            fault_addr_o     <= '0;
            viol_count_o     <= '0;
        end else begin
            fault_valid_o    <= fv_d;
            fault_is_write_o <= fw_d;
            fault_addr_o     <= fa_d;
            viol_count_o     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_axi_addr_window_monitor.sv
// Randomized bench for axi_addr_window_monitor against a queue-based reference model,
// with directed sequences for stall, simultaneous violations, saturation, clear and reset.
module tb_axi_addr_window_monitor;
    localparam int AW   = 32;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] base, limit;
    logic          clr;
    logic          fault_valid, fault_is_write;
    logic [AW-1:0] fault_addr;
    logic [CW-1:0] viol_count;

    axi_addr_window_monitor_if #(.AXI_ADDR_WIDTH(AW)) bus ();

    axi_addr_window_monitor #(.AXI_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) u_dut (
        .S_AXI_ACLK       (clk),
        .S_AXI_ARESET     (rst),
        .win_base_i       (base),
        .win_limit_i      (limit),
        .clear_i          (clr),
        .bus              (bus),
        .fault_valid_o    (fault_valid),
        .fault_is_write_o (fault_is_write),
        .fault_addr_o     (fault_addr),
        .viol_count_o     (viol_count)
    );

    always #5 clk = ~clk;

    logic [AW-1:0] qaw[$];
    logic [AW-1:0] qar[$];
    int            m_cnt;
    bit            m_fv, m_fw;
    logic [AW-1:0] m_fa;
    int            n_vec = 0;
    int            n_bad = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit outside(logic [AW-1:0] a);
        return (a < base) || (a >= limit);
    endfunction

    task automatic drive(bit r, bit c,
                         bit awv, logic [AW-1:0] awa, bit awr,
                         bit arv, logic [AW-1:0] ara, bit arr);
        rst             = r;
        clr             = c;
        bus.s_awvalid_i = awv;
        bus.s_awaddr_i  = awa;
        bus.m_awready_i = awr;
        bus.s_arvalid_i = arv;
        bus.s_araddr_i  = ara;
        bus.m_arready_i = arr;
    endtask

    // Model: each channel is a depth-2 FIFO that accepts only when not full.
    task automatic model_edge();
        bit awacc, aracc, awx, arx;
        if (rst) begin
            qaw.delete();
            qar.delete();
            m_cnt = 0;
            m_fv  = 0;
            m_fw  = 0;
            m_fa  = '0;
            return;
        end
        awacc = bus.s_awvalid_i && (qaw.size() < 2);
        aracc = bus.s_arvalid_i && (qar.size() < 2);
        awx   = awacc && outside(bus.s_awaddr_i);
        arx   = aracc && outside(bus.s_araddr_i);
        if (qaw.size() > 0 && bus.m_awready_i) void'(qaw.pop_front());
        if (qar.size() > 0 && bus.m_arready_i) void'(qar.pop_front());
        if (awacc) qaw.push_back(bus.s_awaddr_i);
        if (aracc) qar.push_back(bus.s_araddr_i);
        if (clr) begin
            m_fv  = 0;
            m_fw  = 0;
            m_fa  = '0;
            m_cnt = 0;
        end
        m_cnt = m_cnt + int'(awx) + int'(arx);
        if (m_cnt > CMAX) m_cnt = CMAX;
        if (!m_fv && (awx || arx)) begin
            m_fv = 1;
            m_fw = awx;
            m_fa = awx ? bus.s_awaddr_i : bus.s_araddr_i;
        end
    endtask

    task automatic compare();
        chk("aw_ready", 64'(bus.s_awready_o), 64'(qaw.size() < 2));
        chk("aw_valid", 64'(bus.m_awvalid_o), 64'(qaw.size() > 0));
        if (qaw.size() > 0) chk("aw_addr", 64'(bus.m_awaddr_o), 64'(qaw[0]));
        chk("ar_ready", 64'(bus.s_arready_o), 64'(qar.size() < 2));
        chk("ar_valid", 64'(bus.m_arvalid_o), 64'(qar.size() > 0));
        if (qar.size() > 0) chk("ar_addr", 64'(bus.m_araddr_o), 64'(qar[0]));
        chk("fault_valid", 64'(fault_valid), 64'(m_fv));
        chk("fault_is_write", 64'(fault_is_write), 64'(m_fw));
        chk("fault_addr", 64'(fault_addr), 64'(m_fa));
        chk("viol_count", 64'(viol_count), 64'(m_cnt));
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        compare();
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return base - 32'd4;
            1:       return base;
            2:       return base + 32'h40;
            3:       return limit - 32'd4;
            4:       return limit;
            default: return AW'($urandom);
        endcase
    endfunction

    initial begin
        base  = 32'h1000_0000;
        limit = 32'h2000_0000;
        drive(1, 0, 0, '0, 0, 0, '0, 0);
        @(negedge clk);
        step();
        chk("rst_awready", 64'(bus.s_awready_o), 64'd1);
        chk("rst_count", 64'(viol_count), 64'd0);
        drive(0, 0, 0, '0, 1, 0, '0, 1);
        step();

        // in-window write forwarded with one cycle latency
        drive(0, 0, 1, 32'h1000_0040, 1, 0, '0, 1);
        step();
        chk("t1_awvalid", 64'(bus.m_awvalid_o), 64'd1);
        chk("t1_awaddr", 64'(bus.m_awaddr_o), 64'h1000_0040);
        drive(0, 0, 0, '0, 1, 0, '0, 1);
        step();
        chk("t1_fault", 64'(fault_valid), 64'd0);

        // stall: A out, B in skid, C held off
        base  = 32'h0;
        limit = 32'hFFFF_FFFF;
        drive(0, 0, 0, '0, 1, 1, 32'hA, 0);
        step();
        drive(0, 0, 0, '0, 1, 1, 32'hB, 0);
        step();
        chk("t2_arready", 64'(bus.s_arready_o), 64'd0);
        chk("t2_araddr", 64'(bus.m_araddr_o), 64'hA);
        drive(0, 0, 0, '0, 1, 1, 32'hC, 0);
        step();
        drive(0, 0, 0, '0, 1, 1, 32'hC, 1);
        step();
        chk("t2_B", 64'(bus.m_araddr_o), 64'hB);
        step();
        chk("t2_C", 64'(bus.m_araddr_o), 64'hC);
        drive(0, 0, 0, '0, 1, 0, '0, 1);
        step();

        // simultaneous AW/AR violation: AW wins the record
        base  = 32'h1000_0000;
        limit = 32'h2000_0000;
        drive(0, 1, 0, '0, 1, 0, '0, 1);
        step();
        drive(0, 0, 1, 32'h0FFF_FFFC, 1, 1, 32'h2000_0000, 1);
        step();
        chk("t3_is_write", 64'(fault_is_write), 64'd1);
        chk("t3_addr", 64'(fault_addr), 64'h0FFF_FFFC);
        chk("t3_count", 64'(viol_count), 64'd2);

        // saturation at 2^CW-1
        drive(0, 1, 0, '0, 1, 0, '0, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, '0, 1, 1, 32'h100 + 32'(i), 1);
            step();
        end
        drive(0, 0, 0, '0, 1, 0, '0, 1);
        step();
        chk("t4_count", 64'(viol_count), 64'(CMAX));
        chk("t4_addr", 64'(fault_addr), 64'h100);

        // clear with a same-cycle violation
        drive(0, 1, 0, '0, 1, 1, 32'h3000_0000, 1);
        step();
        chk("t5_addr", 64'(fault_addr), 64'h3000_0000);
        chk("t5_is_write", 64'(fault_is_write), 64'd0);
        chk("t5_count", 64'(viol_count), 64'd1);

        // reset with both skids full
        drive(0, 0, 1, 32'h1000_0000, 0, 1, 32'h1000_0004, 0);
        step();
        step();
        chk("t6_full", 64'(bus.s_awready_o), 64'd0);
        drive(1, 0, 1, 32'h1000_0000, 0, 1, 32'h1000_0004, 0);
        step();
        chk("t6_awvalid", 64'(bus.m_awvalid_o), 64'd0);
        chk("t6_arready", 64'(bus.s_arready_o), 64'd1);
        chk("t6_count", 64'(viol_count), 64'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                base = AW'($urandom) & 32'hFFFF_F000;
                if ($urandom_range(0, 3) == 0)
                    limit = base - AW'($urandom_range(0, 4096));
                else
                    limit = base + AW'($urandom_range(1, 32'h10000));
            end
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 24) == 0,
                  1'($urandom), pick_addr(), 1'($urandom),
                  1'($urandom), pick_addr(), 1'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
